// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store bus between the CPU and the data-memory responder
interface dmem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle word memory with programmable wait states
// Optional misaligned-access error reporting: define DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WIDX_W = ADDR_W - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WIDX_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] rdata_q;
    logic              arm_q;
    logic              enter_resp;
    logic              in_range;
    logic              addr_mis;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_mis = |bus.addr[1:0];
`else
    logic unused_addr_lsbs;
    assign addr_mis         = 1'b0;
    assign unused_addr_lsbs = ^bus.addr[1:0];
`endif

    // In WAIT the _d copies equal the latched values, so _d always describes the live transaction.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mis_d      = mis_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req && arm_q) begin
                    idx_d   = bus.addr[ADDR_W-1:2];
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    mis_d   = addr_mis;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_range = (32'(idx_d) < DEPTH);

    // arm_q keeps accepts (and therefore array commits) off while reset is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            arm_q   <= 1'b1;
            if (enter_resp && !we_d && !mis_d)
                rdata_q <= in_range ? mem[idx_d[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (enter_resp && we_d && in_range && !mis_d)
            mem[idx_d[IDX_W-1:0]] <= wdata_d;
    end

    assign bus.ack   = (state_q == S_RESP);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.err   = (state_q == S_RESP) && mis_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bw ();
    dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bz ();

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .clock (clk),
        .reset (rst),
        .bus   (bw)
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clock (clk),
        .reset (rst),
        .bus   (bz)
    );

    always #5 clk = ~clk;

    // Drives one request, holds req until ack, reports cycles from accept edge to ack.
    task automatic txn(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic e);
        lat = -1;
        rd  = 'x;
        e   = 'x;
        @(negedge clk);
        if (sel) begin
            bz.req = 1'b1; bz.we = w; bz.addr = a; bz.wdata = d;
        end else begin
            bw.req = 1'b1; bw.we = w; bw.addr = a; bw.wdata = d;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel ? bz.ack : bw.ack) begin
                lat = k;
                rd  = sel ? bz.rdata : bw.rdata;
                e   = sel ? bz.err : bw.err;
                break;
            end
        end
        bw.req = 1'b0;
        bz.req = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++; if (bw.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bw.ack); end
        checks++; if (bw.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bw.busy); end
        checks++; if (bw.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bw.err); end
        checks++; if (bw.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", bw.rdata); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int lat; logic [15:0] rd; logic e;
        txn(1'b0, 1'b1, 16'h0004, 16'h0005, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
        txn(1'b0, 1'b0, 16'h0004, 16'h0000, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL rd_data: got %h expected 0005", rd); end
    endtask

    task automatic test_reset_idle;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bw.rdata !== 16'h0000) begin errors++; $display("FAIL idle_reset_rdata: got %h expected 0000", bw.rdata); end
        checks++; if (bw.busy !== 1'b0) begin errors++; $display("FAIL idle_reset_busy: got %b expected 0", bw.busy); end
        checks++; if (bw.ack !== 1'b0) begin errors++; $display("FAIL idle_reset_ack: got %b expected 0", bw.ack); end
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat1, lat2; logic b4; logic [15:0] rd;
        lat1 = -1; lat2 = -1; b4 = 1'bx; rd = 'x;
        @(negedge clk);
        bw.req = 1'b1; bw.we = 1'b1; bw.addr = 16'h0000; bw.wdata = 16'h0007;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) b4 = bw.busy;
            if (bw.ack) begin
                if (lat1 < 0) begin
                    lat1 = k;
                    bw.we = 1'b0;
                end else begin
                    lat2 = k;
                    rd   = bw.rdata;
                    break;
                end
            end
        end
        bw.req = 1'b0;
        checks++; if (lat1 !== 3) begin errors++; $display("FAIL b2b_first_ack: got %0d expected 3", lat1); end
        checks++; if (b4 !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", b4); end
        checks++; if (lat2 !== 7) begin errors++; $display("FAIL b2b_second_ack: got %0d expected 7", lat2); end
        checks++; if (rd !== 16'h0007) begin errors++; $display("FAIL b2b_rdata: got %h expected 0007", rd); end
    endtask

    task automatic test_out_of_range;
        int lat; logic [15:0] rd; logic e;
        txn(1'b0, 1'b1, 16'h1000, 16'hBEEF, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_ack: got %0d expected 3", lat); end
        txn(1'b0, 1'b0, 16'h1000, 16'h0000, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_ack: got %0d expected 3", lat); end
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL oor_rd_data: got %h expected 0000", rd); end
        txn(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, e);
        checks++; if (rd !== 16'h0007) begin errors++; $display("FAIL oor_word0: got %h expected 0007", rd); end
    endtask

    task automatic test_reset_wait;
        int lat, acks; logic [15:0] rd; logic e;
        txn(1'b0, 1'b1, 16'h0008, 16'h1111, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rw_first_ack: got %0d expected 3", lat); end
        @(negedge clk);
        bw.req = 1'b1; bw.we = 1'b1; bw.addr = 16'h0008; bw.wdata = 16'h1234;
        @(negedge clk);
        checks++; if (bw.busy !== 1'b1) begin errors++; $display("FAIL rw_busy_wait: got %b expected 1", bw.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bw.busy !== 1'b0) begin errors++; $display("FAIL rw_busy_abort: got %b expected 0", bw.busy); end
        bw.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bw.ack) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rw_no_ack: got %0d acks expected 0", acks); end
        txn(1'b0, 1'b0, 16'h0008, 16'h0000, lat, rd, e);
        checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL rw_old_data: got %h expected 1111", rd); end
    endtask

    task automatic test_zero_wait_align;
        int lat; logic [15:0] rd; logic e;
        logic exp_err; logic [15:0] exp_w1;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_w1 = 16'hAAAA;
`else
        exp_err = 1'b0; exp_w1 = 16'h5555;
`endif
        txn(1'b1, 1'b1, 16'h0004, 16'hAAAA, lat, rd, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_wr_latency: got %0d expected 1", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL w0_aligned_err: got %b expected 0", e); end
        txn(1'b1, 1'b0, 16'h0004, 16'h0000, lat, rd, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_rd_latency: got %0d expected 1", lat); end
        checks++; if (rd !== 16'hAAAA) begin errors++; $display("FAIL w0_rd_data: got %h expected aaaa", rd); end
        txn(1'b1, 1'b1, 16'h0006, 16'h5555, lat, rd, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_mis_latency: got %0d expected 1", lat); end
        checks++; if (e !== exp_err) begin errors++; $display("FAIL w0_mis_err: got %b expected %b", e, exp_err); end
        txn(1'b1, 1'b0, 16'h0006, 16'h0000, lat, rd, e);
        checks++; if (rd !== exp_w1) begin errors++; $display("FAIL w0_mis_rd: got %h expected %h", rd, exp_w1); end
        txn(1'b1, 1'b0, 16'h0004, 16'h0000, lat, rd, e);
        checks++; if (rd !== exp_w1) begin errors++; $display("FAIL w0_word1: got %h expected %h", rd, exp_w1); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL w0_aligned_rd_err: got %b expected 0", e); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b0;
        bw.req = 1'b0; bw.we = 1'b0; bw.addr = '0; bw.wdata = '0;
        bz.req = 1'b0; bz.we = 1'b0; bz.addr = '0; bz.wdata = '0;
        test_reset;
        test_write_read;
        test_reset_idle;
        test_back_to_back;
        test_out_of_range;
        test_reset_wait;
        test_zero_wait_align;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the 16-bit CPU's load/store port. The CPU side acts as initiator and raises req; this block serves it.
- Holds a word array, accepts one read or write per transaction, inserts programmable wait states, then returns a one-cycle ack with read data.
- Replaces the zero-latency DMemory array so the CPU can stall on real memory latency.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, byte-address width
- DEPTH, 1024, number of words in the array
- WAIT_CYCLES, 2, wait states inserted between accept and response (legal range 0..15)

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  request valid; the initiator holds it high until it sees ack
- we  input  1  1 = write, 0 = read; sampled at accept
- addr  input  ADDR_W  byte address; word index is addr>>2
- wdata  input  DATA_W  write data; sampled at accept
- ack  output  1  one-cycle response strobe
- rdata  output  DATA_W  read data; valid while ack=1 on a read, held afterwards
- busy  output  1  high from the cycle after accept until ack is deasserted
- err  output  1  error flag; always 0 unless DMEM_ALIGN_CHECK_EN is defined

Behaviour:
- Reset values: ack=0, busy=0, err=0, rdata=0; FSM returns to IDLE and the wait counter clears. Array contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If req=1 at an edge, latch addr, we and wdata, and load cnt=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
  - busy=0 in this state.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt equals 1, go to RESP.
  - busy=1; req and other inputs are ignored.
- RESP:
  - ack=1 and busy=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: ack is high in the (WAIT_CYCLES+1)th cycle after the accept edge.
- Throughput: with req held high, a new accept occurs on the edge leaving RESP+1, i.e. the first IDLE cycle. One transaction per WAIT_CYCLES+2 cycles.
- Array commit:
  - Writes commit on the edge entering RESP; a read of the same word in the next transaction returns the new value.
  - Reads capture the array into rdata on the edge entering RESP.
- rdata is unchanged by writes and holds its last read value.
- Out of range (addr>>2 >= DEPTH): the write is dropped, a read returns 0, and ack is still issued.
- Latched values are used for the whole transaction; changes on addr, we or wdata after accept have no effect.
- Reset mid-transaction: abort at once with no ack. A write not yet committed never reaches the array.
- req deasserted during WAIT does not cancel the transaction; ack is still produced.

Optional Feature:
- DMEM_ALIGN_CHECK_EN
- Defined:
  - If the latched addr[1:0] != 0, the transaction still takes full latency.
  - err=1 together with ack for that single cycle; the write is suppressed and rdata is left unchanged.
  - err=0 otherwise.
- Undefined: err is tied to 0 and addr[1:0] is ignored, so the word index is addr>>2.

Test Plan:
- Reset: assert reset mid-idle -> ack=0, busy=0, err=0, rdata=0x0000 immediately, without waiting for a clock edge.
- Write then read, WAIT_CYCLES=2:
  - Write addr=0x0004, wdata=0x0005 -> ack in the 3rd cycle after accept.
  - Then read addr=0x0004 -> rdata=0x0005 with ack, 3 cycles after its accept.
- Back-to-back with req held high:
  - Write 0x0000=0x0007, then read 0x0000.
  - Second accept occurs in the cycle after ack falls; rdata=0x0007; total 8 cycles for both.
- Out of range: write addr=0x1000 (index 1024) data=0xBEEF, then read 0x1000 -> both ack'd, rdata=0x0000; word 0 remains 0x0007.
- Reset mid-WAIT:
  - First write addr=0x0008 with 0x1111 to completion.
  - Start a write of 0x1234 to the same address and pulse reset in WAIT -> no ack.
  - A subsequent read of 0x0008 returns 0x1111.
- WAIT_CYCLES=0 plus alignment:
  - Ack is high in the cycle after accept.
  - With DMEM_ALIGN_CHECK_EN, a write to addr=0x0006 -> err=1 with ack and word 1 unchanged.
  - Without the macro, the same write updates word 1 and err=0.
